// File: rtl/risc_seq_ctrl.sv
// Multi-cycle RISC sequencer (FETCH/DECODE/EXEC/MEM/WB) with interrupt entry/return; strobes decode from registered state.
// Memory phases stall indefinitely on memAck; define SEQ_PERF_CNT_EN to add cycCnt/instRet counters.
module risc_seq_ctrl #(
  parameter bit IE_RST = 1'b1,
  parameter int SW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          INT,
  input  logic [5:0]    opcode,
  input  logic          isBranch,
  input  logic          memAck,
  output logic          memReq,
  output logic          rdMem,
  output logic          wrMem,
  output logic          irLoad,
  output logic          wrReg,
  output logic          updPC,
  output logic [1:0]    pcSel,
  output logic          epcLoad,
  output logic          intAck,
  output logic          ie,
  output logic          halted,
  output logic [SW-1:0] state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   cycCnt,
  output logic [31:0]   instRet
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_INTE   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_LD, C_ST, C_BR, C_RETI, C_EI, C_DI, C_HALT
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, cls_dec;
  logic   ie_q, ie_d;
  logic   pend_q;
  logic   idle_q;
  logic   boundary;

  always_comb begin
    cls_dec = C_NOP;
    casez (opcode)
      6'b000???, 6'b001???: cls_dec = C_ALU;
      6'b010000:            cls_dec = C_LD;
      6'b010001:            cls_dec = C_ST;
      6'b100???:            cls_dec = C_BR;
      6'b110000:            cls_dec = C_RETI;
      6'b110001:            cls_dec = C_EI;
      6'b110010:            cls_dec = C_DI;
      6'b111111:            cls_dec = C_HALT;
      default:              cls_dec = C_NOP;
    endcase
  end

  // idle_q keeps the first post-reset cycle quiet so a stale memAck cannot complete a fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NOP;
      ie_q    <= IE_RST;
      pend_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      pend_q  <= INT;
      idle_q  <= 1'b0;
      if (state_q == S_DECODE) cls_q <= cls_dec;
    end
  end

  always_comb begin
    state_d  = state_q;
    ie_d     = ie_q;
    boundary = 1'b0;
    case (state_q)
      S_FETCH:  if (!idle_q && memAck) state_d = S_DECODE;
      S_DECODE: begin
        case (cls_dec)
          C_ALU, C_LD, C_ST, C_BR: state_d = S_EXEC;
          C_HALT:                  state_d = S_HALT;
          C_RETI, C_EI: begin ie_d = 1'b1; boundary = 1'b1; end
          C_DI:         begin ie_d = 1'b0; boundary = 1'b1; end
          default:      boundary = 1'b1;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BR:       boundary = 1'b1;
          C_LD, C_ST: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (memAck) begin
          if (cls_q == C_LD) state_d = S_WB;
          else               boundary = 1'b1;
        end
      end
      S_WB:   boundary = 1'b1;
      S_INTE: begin ie_d = 1'b0; state_d = S_FETCH; end
      S_HALT: if (pend_q && ie_q) state_d = S_INTE;
      default: state_d = S_FETCH;
    endcase
    // ie_d already reflects RETI/EI/DI, so an interrupt is taken right after RETI
    if (boundary) state_d = (pend_q && ie_d) ? S_INTE : S_FETCH;
  end

  always_comb begin
    memReq  = 1'b0;
    rdMem   = 1'b0;
    wrMem   = 1'b0;
    irLoad  = 1'b0;
    wrReg   = 1'b0;
    updPC   = 1'b0;
    pcSel   = 2'b00;
    epcLoad = 1'b0;
    intAck  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memReq = !idle_q;
        rdMem  = !idle_q;
        irLoad = !idle_q && memAck;
      end
      S_DECODE: begin
        if (!(cls_dec inside {C_ALU, C_LD, C_ST, C_BR})) begin
          updPC = 1'b1;
          pcSel = (cls_dec == C_RETI) ? 2'b11 : 2'b00;
        end
      end
      S_EXEC: begin
        if (cls_q == C_BR) begin
          updPC = 1'b1;
          pcSel = isBranch ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        memReq = 1'b1;
        rdMem  = (cls_q == C_LD);
        wrMem  = (cls_q == C_ST);
        updPC  = memAck && (cls_q == C_ST);
      end
      S_WB: begin
        wrReg = 1'b1;
        updPC = 1'b1;
      end
      S_INTE: begin
        epcLoad = 1'b1;
        updPC   = 1'b1;
        pcSel   = 2'b10;
        intAck  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ie     = ie_q;
  assign halted = (state_q == S_HALT);
  assign state  = SW'(state_q);

`ifdef SEQ_PERF_CNT_EN
  logic retire;
  assign retire = boundary || (state_q == S_DECODE && cls_dec == C_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycCnt  <= '0;
      instRet <= '0;
    end else begin
      if (state_q != S_HALT) cycCnt <= cycCnt + 32'd1;
      if (retire) instRet <= instRet + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Directed bench for risc_seq_ctrl: each stimulus cycle queues its hand-computed expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_risc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, INT, isBranch, memAck;
  logic [5:0] opcode;
  logic       memReq, rdMem, wrMem, irLoad, wrReg, updPC, epcLoad, intAck, ie, halted;
  logic [1:0] pcSel;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycCnt, instRet;
`endif

  risc_seq_ctrl #(.IE_RST(1'b1), .SW(3)) dut (
    .clk(clk), .rst(rst), .INT(INT), .opcode(opcode), .isBranch(isBranch), .memAck(memAck),
    .memReq(memReq), .rdMem(rdMem), .wrMem(wrMem), .irLoad(irLoad), .wrReg(wrReg),
    .updPC(updPC), .pcSel(pcSel), .epcLoad(epcLoad), .intAck(intAck), .ie(ie),
    .halted(halted), .state(state)
`ifdef SEQ_PERF_CNT_EN
    , .cycCnt(cycCnt), .instRet(instRet)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, rd, wr, irl, wrr, upd;
    logic [1:0] pcs;
    logic       epc, iak, iev, hlt;
  } obs_t;

  typedef struct {
    obs_t  e;
    int    n;
    string ph;
  } item_t;

  localparam int RD = 1, WR = 2;
  localparam logic [4:0] NONE = 5'b00000, IRL = 5'b10000, WRR = 5'b01000,
                         UPD = 5'b00100, EPC = 5'b00010, IAK = 5'b00001;
  localparam logic [5:0] OP_ALU = 6'b000000, OP_ALUI = 6'b001010, OP_LD = 6'b010000,
                         OP_ST = 6'b010001, OP_BR = 6'b100000, OP_RETI = 6'b110000,
                         OP_EI = 6'b110001, OP_DI = 6'b110010, OP_HALT = 6'b111111,
                         OP_NOP = 6'b011000;

  item_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    step_no = 0;
  string phase = "init";

  function automatic obs_t mk(input int st, input int mem, input logic [4:0] s,
                              input logic [1:0] pcs, input logic iev);
    obs_t o;
    logic [31:0] stv;
    stv   = st;
    o.st  = stv[2:0];
    o.mreq = (mem != 0);
    o.rd  = (mem == RD);
    o.wr  = (mem == WR);
    o.irl = s[4];
    o.wrr = s[3];
    o.upd = s[2];
    o.epc = s[1];
    o.iak = s[0];
    o.pcs = pcs;
    o.iev = iev;
    o.hlt = (st == 6);
    return o;
  endfunction

  task automatic cyc(input logic i, input logic b, input logic a, input logic [5:0] op,
                     input obs_t e);
    item_t it;
    rst = 1'b0; INT = i; isBranch = b; memAck = a; opcode = op;
    step_no++;
    it.e = e; it.n = step_no; it.ph = phase;
    exp_q.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic rcyc(input logic a);
    rst = 1'b1; INT = 1'b0; isBranch = 1'b0; memAck = a;
    step_no++;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      obs_t  act;
      it  = exp_q.pop_front();
      act = '{st: state, mreq: memReq, rd: rdMem, wr: wrMem, irl: irLoad, wrr: wrReg,
              upd: updPC, pcs: pcSel, epc: epcLoad, iak: intAck, iev: ie, hlt: halted};
      // pcSel only carries meaning on an updPC cycle
      if (!it.e.upd) act.pcs = it.e.pcs;
      checks++;
      if (act !== it.e) begin
        failures++;
        $display("FAIL %s step%0d: got st=%0d req/rd/wr/irl/wrr/upd=%b%b%b%b%b%b pcs=%b epc/iak/ie/hlt=%b%b%b%b, want st=%0d req/rd/wr/irl/wrr/upd=%b%b%b%b%b%b pcs=%b epc/iak/ie/hlt=%b%b%b%b",
                 it.ph, it.n,
                 act.st, act.mreq, act.rd, act.wr, act.irl, act.wrr, act.upd, act.pcs,
                 act.epc, act.iak, act.iev, act.hlt,
                 it.e.st, it.e.mreq, it.e.rd, it.e.wr, it.e.irl, it.e.wrr, it.e.upd, it.e.pcs,
                 it.e.epc, it.e.iak, it.e.iev, it.e.hlt);
      end
    end
  end

  initial begin
    rst = 1'b1; INT = 1'b0; isBranch = 1'b0; memAck = 1'b0; opcode = OP_ALU;
    @(posedge clk); #1;
    rcyc(1'b0);

    phase = "reset";
    cyc(0, 0, 0, OP_ALU, mk(0, 0, NONE, 2'b00, 1));

    phase = "alu_r";
    cyc(0, 0, 1, OP_ALU, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_ALU, mk(1, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_ALU, mk(2, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_ALU, mk(4, 0, WRR | UPD, 2'b00, 1));

    phase = "ld_slow";
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, OP_LD, mk(0, RD, NONE, 2'b00, 1));
    cyc(0, 0, 1, OP_LD, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_LD, mk(1, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_LD, mk(2, 0, NONE, 2'b00, 1));
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, OP_LD, mk(3, RD, NONE, 2'b00, 1));
    cyc(0, 0, 1, OP_LD, mk(3, RD, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_LD, mk(4, 0, WRR | UPD, 2'b00, 1));

    phase = "st_stray_ack";
    cyc(0, 0, 1, OP_ST, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 1, OP_ST, mk(1, 0, NONE, 2'b00, 1));
    cyc(0, 0, 1, OP_ST, mk(2, 0, NONE, 2'b00, 1));
    cyc(0, 0, 1, OP_ST, mk(3, WR, UPD, 2'b00, 1));

    phase = "br_taken";
    cyc(0, 0, 1, OP_BR, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_BR, mk(1, 0, NONE, 2'b00, 1));
    cyc(0, 1, 0, OP_BR, mk(2, 0, UPD, 2'b01, 1));

    phase = "br_not_taken";
    cyc(0, 0, 1, OP_BR, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 1, 0, OP_BR, mk(1, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_BR, mk(2, 0, UPD, 2'b00, 1));

    phase = "nop";
    cyc(0, 0, 1, OP_NOP, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_NOP, mk(1, 0, UPD, 2'b00, 1));

    phase = "int_entry";
    cyc(0, 0, 1, OP_ALU, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_ALU, mk(1, 0, NONE, 2'b00, 1));
    cyc(1, 0, 0, OP_ALU, mk(2, 0, NONE, 2'b00, 1));
    cyc(1, 0, 0, OP_ALU, mk(4, 0, WRR | UPD, 2'b00, 1));
    cyc(1, 0, 0, OP_ALU, mk(5, 0, UPD | EPC | IAK, 2'b10, 1));

    phase = "int_masked";
    cyc(1, 0, 1, OP_ALU, mk(0, RD, IRL, 2'b00, 0));
    cyc(1, 0, 0, OP_ALU, mk(1, 0, NONE, 2'b00, 0));
    cyc(1, 0, 0, OP_ALU, mk(2, 0, NONE, 2'b00, 0));
    cyc(1, 0, 0, OP_ALU, mk(4, 0, WRR | UPD, 2'b00, 0));

    phase = "reti";
    cyc(1, 0, 1, OP_RETI, mk(0, RD, IRL, 2'b00, 0));
    cyc(1, 0, 0, OP_RETI, mk(1, 0, UPD, 2'b11, 0));
    cyc(0, 0, 0, OP_RETI, mk(5, 0, UPD | EPC | IAK, 2'b10, 1));

    phase = "ei";
    cyc(0, 0, 1, OP_EI, mk(0, RD, IRL, 2'b00, 0));
    cyc(0, 0, 0, OP_EI, mk(1, 0, UPD, 2'b00, 0));

    phase = "halt";
    cyc(0, 0, 1, OP_HALT, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_HALT, mk(1, 0, UPD, 2'b00, 1));
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, OP_HALT, mk(6, 0, NONE, 2'b00, 1));

    phase = "halt_wake";
    cyc(1, 0, 0, OP_HALT, mk(6, 0, NONE, 2'b00, 1));
    cyc(1, 0, 0, OP_HALT, mk(6, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_HALT, mk(5, 0, UPD | EPC | IAK, 2'b10, 1));

    phase = "di";
    cyc(0, 0, 1, OP_DI, mk(0, RD, IRL, 2'b00, 0));
    cyc(0, 0, 0, OP_DI, mk(1, 0, UPD, 2'b00, 0));

    phase = "halt_masked";
    cyc(0, 0, 1, OP_HALT, mk(0, RD, IRL, 2'b00, 0));
    cyc(1, 0, 0, OP_HALT, mk(1, 0, UPD, 2'b00, 0));
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, OP_HALT, mk(6, 0, NONE, 2'b00, 0));

    phase = "rst_from_halt";
    rcyc(1'b0);
    cyc(0, 0, 0, OP_DI, mk(0, 0, NONE, 2'b00, 1));
    cyc(0, 0, 1, OP_DI, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_DI, mk(1, 0, UPD, 2'b00, 1));

    phase = "rst_in_mem";
    cyc(0, 0, 1, OP_LD, mk(0, RD, IRL, 2'b00, 0));
    cyc(0, 0, 0, OP_LD, mk(1, 0, NONE, 2'b00, 0));
    cyc(0, 0, 0, OP_LD, mk(2, 0, NONE, 2'b00, 0));
    cyc(0, 0, 0, OP_LD, mk(3, RD, NONE, 2'b00, 0));
    cyc(0, 0, 0, OP_LD, mk(3, RD, NONE, 2'b00, 0));
    rcyc(1'b1);
    cyc(0, 0, 1, OP_ALUI, mk(0, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_ALUI, mk(0, RD, NONE, 2'b00, 1));
    cyc(0, 0, 1, OP_ALUI, mk(0, RD, IRL, 2'b00, 1));
    cyc(0, 0, 0, OP_ALUI, mk(1, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_ALUI, mk(2, 0, NONE, 2'b00, 1));
    cyc(0, 0, 0, OP_ALUI, mk(4, 0, WRR | UPD, 2'b00, 1));
    cyc(0, 0, 0, OP_ALUI, mk(0, RD, NONE, 2'b00, 1));

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
